// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Drives six active-low board LEDs with one of three animations, chosen by a
// mode button and frozen or unfrozen by a pause button.
//   COUNT  : 6-bit binary up-counter
//   BOUNCE : single lit LED sweeping left and right
//   BLINK  : all LEDs toggling together
// Each animation advances one step every WAIT_TIME clock cycles. Both buttons
// are asynchronous and active-low. Each one is synchronized, debounced over
// DEBOUNCE stable cycles, and reduced to a one-cycle press event.
//
// Ports
//   clk       : single clock, all state on the rising edge
//   rst_n     : synchronous active-low reset
//   btn_mode  : async active-low button, cycles COUNT -> BOUNCE -> BLINK
//   btn_pause : async active-low button, toggles paused
//   led[5:0]  : active-low LED drive (~pattern)
//   mode[1:0] : current state (COUNT=0, BOUNCE=1, BLINK=2)
//   paused    : high while stepping is frozen
//   tick      : one-cycle pulse in the cycle a new pattern step is shown
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int unsigned WAIT_TIME = 13500000,
  parameter int unsigned DEBOUNCE  = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_pause,
  output logic [5:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       tick
);

  localparam logic [23:0] PRESC_LAST = 24'(WAIT_TIME - 1);
  localparam logic [19:0] DB_LAST    = 20'(DEBOUNCE - 1);
  localparam logic        DIR_LEFT   = 1'b0;
  localparam logic        DIR_RIGHT  = 1'b1;
  localparam int          BTN_MODE   = 0;
  localparam int          BTN_PAUSE  = 1;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_BLINK  = 2'd2
  } state_e;

  // Next {direction, pattern} for one bounce step. The direction flips at the
  // end positions, so the lit bit never leaves the 6-bit field. A pattern that
  // is not one-hot recovers to the entry value.
  function automatic logic [6:0] bounce_next(input logic [5:0] pat, input logic dir);
    logic [6:0] res;
    case (pat)
      6'b000001: res = {DIR_LEFT, 6'b000010};
      6'b100000: res = {DIR_RIGHT, 6'b010000};
      6'b000010,
      6'b000100,
      6'b001000,
      6'b010000: begin
        if (dir == DIR_LEFT) begin
          res = {DIR_LEFT, pat << 1};
        end else begin
          res = {DIR_RIGHT, pat >> 1};
        end
      end
      default:   res = {DIR_LEFT, 6'b000001};
    endcase
    return res;
  endfunction

  // Button index 0 is mode and index 1 is pause.
  logic [1:0]       btn_raw_s;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       db_lvl_q, db_lvl_d;
  logic [1:0][19:0] db_cnt_q, db_cnt_d;
  logic [1:0]       press_s;

  state_e           state_q, state_d;
  logic [5:0]       pattern_q, pattern_d;
  logic             dir_q, dir_d;
  logic [23:0]      presc_q, presc_d;
  logic             paused_q, paused_d;
  logic             tick_q, tick_d;
  logic             step_s;
  logic [6:0]       bounce_s;

  assign btn_raw_s = {btn_pause, btn_mode};

  // Synchronizer shift and debounce counters. A press is the cycle in which
  // the debounced level is about to fall from 1 to 0.
  always_comb begin
    sync1_d = btn_raw_s;
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      db_lvl_d[i] = db_lvl_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      press_s[i]  = 1'b0;
      if (sync2_q[i] == db_lvl_q[i]) begin
        db_cnt_d[i] = 20'd0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_lvl_d[i] = sync2_q[i];
        db_cnt_d[i] = 20'd0;
        // The level differs from the sample, so an old level of 1 means it falls now.
        press_s[i]  = db_lvl_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 20'd1;
      end
    end
  end

  // Sequencer next state. A mode press overrides a coincident step.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    presc_d   = presc_q;
    paused_d  = paused_q;
    tick_d    = 1'b0;
    step_s    = (!paused_q) && (presc_q == PRESC_LAST);
    bounce_s  = bounce_next(pattern_q, dir_q);

    if (press_s[BTN_MODE]) begin
      presc_d = 24'd0;
      dir_d   = DIR_LEFT;
      case (state_q)
        ST_COUNT: begin
          state_d   = ST_BOUNCE;
          pattern_d = 6'b000001;
        end
        ST_BOUNCE: begin
          state_d   = ST_BLINK;
          pattern_d = 6'b000000;
        end
        ST_BLINK: begin
          state_d   = ST_COUNT;
          pattern_d = 6'b000000;
        end
        default: begin
          state_d   = ST_COUNT;
          pattern_d = 6'b000000;
        end
      endcase
    end else if (step_s) begin
      presc_d = 24'd0;
      tick_d  = 1'b1;
      case (state_q)
        ST_COUNT:  pattern_d = pattern_q + 6'd1;
        ST_BOUNCE: begin
          dir_d     = bounce_s[6];
          pattern_d = bounce_s[5:0];
        end
        ST_BLINK:  pattern_d = ~pattern_q;
        default: begin
          state_d   = ST_COUNT;
          pattern_d = 6'b000000;
        end
      endcase
    end else if (!paused_q) begin
      presc_d = presc_q + 24'd1;
    end else begin
      presc_d = presc_q;
    end

    if (press_s[BTN_PAUSE]) begin
      paused_d = ~paused_q;
    end else begin
      paused_d = paused_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      db_lvl_q  <= 2'b11;
      db_cnt_q  <= '0;
      state_q   <= ST_COUNT;
      pattern_q <= 6'b000000;
      dir_q     <= DIR_LEFT;
      presc_q   <= 24'd0;
      paused_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_lvl_q  <= db_lvl_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      presc_q   <= presc_d;
      paused_q  <= paused_d;
      tick_q    <= tick_d;
    end
  end

  assign led    = ~pattern_q;
  assign mode   = state_q;
  assign paused = paused_q;
  assign tick   = tick_q;

endmodule
